lsu_ctrl: RTL and testbench

Load/store unit controller for the RV32I core. It sits between execute and data memory and produces the `DM_valid` completion strobe that the program counter uses to release its load stall. It buffers stores in a 2-entry write queue and runs loads through a request/ack FSM. It also performs byte/halfword lane steering, sign/zero extension and alignment checking.

---
 rtl/lsu_ctrl_if.sv | 27 ++
 rtl/lsu_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between the load/store controller (master) and data memory (slave).
// Handshake: mem_req is the valid and mem_ack the completion. The payload (mem_we, mem_addr,
// mem_wdata, mem_wstrb) holds steady from the rise of mem_req through the ack cycle inclusive.
// mem_rdata is sampled in the ack cycle, mem_ack is ignored while mem_req=0, and mem_req
// drops in the cycle after ack.
interface lsu_ctrl_if #(
    parameter int ADDRESS = 32,
    parameter int DATA    = 32
);
    logic                mem_req;
    logic                mem_we;
    logic [ADDRESS-1:0]  mem_addr;
    logic [DATA-1:0]     mem_wdata;
    logic [DATA/8-1:0]   mem_wstrb;
    logic [DATA-1:0]     mem_rdata;
    logic                mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32I load/store controller: a 2-entry store buffer drained ahead of loads, a request/ack
// load FSM, lane steering, sign/zero extension and alignment checks. All outputs are registered.
module lsu_ctrl #(
    parameter int ADDRESS = 32,
    parameter int DATA    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               store,
    input  logic [2:0]         funct3,
    input  logic [ADDRESS-1:0] addr,
    input  logic [DATA-1:0]    store_data,
    output logic               DM_valid,
    output logic [DATA-1:0]    load_data,
    output logic               access_fault,
    output logic               sb_full,
    output logic               sb_overflow,
    output logic [1:0]         state_dbg,
    lsu_ctrl_if.master         mem
);
    localparam int LANES = DATA / 8;

    typedef enum logic [1:0] {IDLE, ST_REQ, LD_REQ, LD_DONE} state_t;
    state_t state, state_n;

    logic [ADDRESS-1:0] q_addr  [2];
    logic [DATA-1:0]    q_wdata [2];
    logic [LANES-1:0]   q_wstrb [2];
    logic               rd_ptr, wr_ptr;
    logic [1:0]         count, count_n;
    logic [2:0]         ld_f3;
    logic [1:0]         ld_lo;

    logic               ld_ok, st_ok, pop, push, drop;
    logic [ADDRESS-1:0] word_addr;
    logic [DATA-1:0]    st_wdata, ld_ext;
    logic [LANES-1:0]   st_wstrb;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;

    assign state_dbg = state;
    assign word_addr = {addr[ADDRESS-1:2], 2'b00};

    // BU/HU exist only for loads, so they are legal loads but illegal stores.
    always_comb begin
        ld_ok = 1'b0;
        st_ok = 1'b0;
        case (funct3)
            3'b000:  begin ld_ok = 1'b1; st_ok = 1'b1; end
            3'b100:  ld_ok = 1'b1;
            3'b001:  begin ld_ok = ~addr[0]; st_ok = ~addr[0]; end
            3'b101:  ld_ok = ~addr[0];
            3'b010:  begin ld_ok = (addr[1:0] == 2'b00); st_ok = (addr[1:0] == 2'b00); end
            default: ;
        endcase
    end

    always_comb begin
        st_wdata = store_data;
        st_wstrb = '1;
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {LANES{store_data[7:0]}};
                st_wstrb = LANES'(1) << addr[1:0];
            end
            2'b01: begin
                st_wdata = {(LANES/2){store_data[15:0]}};
                st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = mem.mem_rdata[{ld_lo, 3'b000} +: 8];
        ld_half = ld_lo[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (ld_f3)
            3'b000:  ld_ext = {{(DATA-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {{(DATA-8){1'b0}}, ld_byte};
            3'b001:  ld_ext = {{(DATA-16){ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {{(DATA-16){1'b0}}, ld_half};
            default: ld_ext = mem.mem_rdata;
        endcase
    end

    // A full buffer still accepts a store in the cycle its head is acked.
    assign pop     = (state == ST_REQ) && mem.mem_ack;
    assign push    = store && st_ok && ((count != 2'd2) || pop);
    assign drop    = store && st_ok && (count == 2'd2) && !pop;
    assign count_n = count + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (count != 2'd0)   state_n = ST_REQ;
                else if (load && ld_ok) state_n = LD_REQ;
                else if (load)       state_n = LD_DONE;
            end
            ST_REQ:  if (mem.mem_ack) state_n = IDLE;
            LD_REQ:  if (mem.mem_ack) state_n = LD_DONE;
            LD_DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr]  <= word_addr;
            q_wdata[wr_ptr] <= st_wdata;
            q_wstrb[wr_ptr] <= st_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            count         <= 2'd0;
            sb_full       <= 1'b0;
            sb_overflow   <= 1'b0;
            ld_f3         <= 3'b000;
            ld_lo         <= 2'b00;
            DM_valid      <= 1'b0;
            load_data     <= '0;
            access_fault  <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count       <= count_n;
            sb_full     <= (count_n == 2'd2);
            sb_overflow <= sb_overflow | drop;

            mem.mem_req  <= (state_n == ST_REQ) || (state_n == LD_REQ);
            mem.mem_we   <= (state_n == ST_REQ);
            DM_valid     <= (state_n == LD_DONE);
            access_fault <= (store && !st_ok) || ((state == IDLE) && (state_n == LD_DONE));

            // The head cannot change while ST_REQ waits, so reloading it keeps the bus stable.
            if (state_n == ST_REQ) begin
                mem.mem_addr  <= q_addr[rd_ptr];
                mem.mem_wdata <= q_wdata[rd_ptr];
                mem.mem_wstrb <= q_wstrb[rd_ptr];
            end else if ((state == IDLE) && (state_n == LD_REQ)) begin
                mem.mem_addr  <= word_addr;
                mem.mem_wstrb <= '0;
                ld_f3         <= funct3;
                ld_lo         <= addr[1:0];
            end

            if ((state == LD_REQ) && mem.mem_ack)
                load_data <= ld_ext;
            else if ((state == IDLE) && (state_n == LD_DONE))
                load_data <= '0;
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a memory responder, load/store drivers and scoreboards
// for load results and memory writes.
module tb_lsu_ctrl;
    logic        clk, rst, load, store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        dm_valid, access_fault, sb_full, sb_overflow;
    logic [31:0] load_data;
    logic [1:0]  state_dbg;

    lsu_ctrl_if mem_bus ();

    lsu_ctrl dut (
        .clk(clk), .rst(rst), .load(load), .store(store), .funct3(funct3), .addr(addr),
        .store_data(store_data), .DM_valid(dm_valid), .load_data(load_data),
        .access_fault(access_fault), .sb_full(sb_full), .sb_overflow(sb_overflow),
        .state_dbg(state_dbg), .mem(mem_bus)
    );

    int checks = 0, failures = 0;
    logic [32:0] exp_q[$];
    logic [67:0] exp_wr_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] rd_value = '0;
    int cur_wait = 0, wait_cnt = 0, wr_acks = 0, dm_wr_acks = 0;
    int store_faults = 0, exp_store_faults = 0;
    logic hold_ack = 0, auto_ack = 0, man_en = 0, man_ack = 0;

    assign mem_bus.mem_ack   = man_en ? man_ack : auto_ack;
    assign mem_bus.mem_rdata = rd_value;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit ld_legal(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'b000, 3'b100: return 1'b1;
            3'b001, 3'b101: return a[0] == 1'b0;
            3'b010:         return a[1:0] == 2'b00;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic bit st_legal(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'b000:  return 1'b1;
            3'b001:  return a[0] == 1'b0;
            3'b010:  return a[1:0] == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a[1:0])
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [35:0] st_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d);
        logic [3:0] s;
        case (f3)
            3'b000: begin
                case (a[1:0])
                    2'd0:    s = 4'b0001;
                    2'd1:    s = 4'b0010;
                    2'd2:    s = 4'b0100;
                    default: s = 4'b1000;
                endcase
                return {d[7:0], d[7:0], d[7:0], d[7:0], s};
            end
            3'b001:  return {d[15:0], d[15:0], (a[1] ? 4'b1100 : 4'b0011)};
            default: return {d, 4'b1111};
        endcase
    endfunction

    // memory responder: acks after cur_wait cycles and scores each transfer on its ack
    initial begin
        forever begin
            @(negedge clk);
            if (auto_ack) check("req_drop", 64'(mem_bus.mem_req), 64'(0));
            auto_ack = 1'b0;
            if (mem_bus.mem_req && !hold_ack && !man_en && !rst) begin
                if (wait_cnt < cur_wait) begin
                    wait_cnt++;
                end else begin
                    auto_ack = 1'b1;
                    wait_cnt = 0;
                    if (mem_bus.mem_we) begin
                        wr_acks++;
                        if (exp_wr_q.size() == 0) check("wr_unexpected", 64'(1), 64'(0));
                        else check("wr_txn", 64'({mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_wstrb}),
                                   64'(exp_wr_q.pop_front()));
                    end else begin
                        if (exp_rd_q.size() == 0) check("rd_unexpected", 64'(1), 64'(0));
                        else check("rd_addr", 64'(mem_bus.mem_addr), 64'(exp_rd_q.pop_front()));
                        check("rd_wstrb", 64'(mem_bus.mem_wstrb), 64'(0));
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // load-completion scoreboard
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (dm_valid) begin
                dm_wr_acks = wr_acks;
                if (exp_q.size() == 0) begin
                    check("dm_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("load_data", 64'(load_data), 64'(e[31:0]));
                    check("load_fault", 64'(access_fault), 64'(e[32]));
                end
            end else if (access_fault) begin
                store_faults++;
            end
        end
    end

    // driver tasks: each starts and ends 1 time unit after a rising edge
    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                           input int w, output int req_c, output int dm_c);
        bit legal;
        legal = ld_legal(f3, a);
        rd_value = rd;
        cur_wait = w;
        exp_q.push_back(legal ? {1'b0, ld_model(f3, a, rd)} : 33'h1_0000_0000);
        if (legal) exp_rd_q.push_back({a[31:2], 2'b00});
        load = 1'b1; funct3 = f3; addr = a;
        req_c = -1; dm_c = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (mem_bus.mem_req && req_c < 0) req_c = k;
            if (dm_valid) begin dm_c = k; break; end
        end
        if (dm_c < 0) check("load_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            input bit expect_push);
        if (expect_push) exp_wr_q.push_back({a[31:2], 2'b00, st_model(f3, a, d)});
        if (!st_legal(f3, a)) exp_store_faults++;
        store = 1'b1; funct3 = f3; addr = a; store_data = d;
        @(posedge clk); #1;
        store = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        check({tag, "_dm_valid"}, 64'(dm_valid), 64'(0));
        check({tag, "_fault"}, 64'(access_fault), 64'(0));
        check({tag, "_sb_full"}, 64'(sb_full), 64'(0));
        check({tag, "_sb_ovf"}, 64'(sb_overflow), 64'(0));
        check({tag, "_req_we"}, 64'({mem_bus.mem_req, mem_bus.mem_we}), 64'(0));
        check({tag, "_addr"}, 64'(mem_bus.mem_addr), 64'(0));
        check({tag, "_wdata"}, 64'(mem_bus.mem_wdata), 64'(0));
        check({tag, "_wstrb"}, 64'(mem_bus.mem_wstrb), 64'(0));
        check({tag, "_ldata"}, 64'(load_data), 64'(0));
        check({tag, "_state"}, 64'(state_dbg), 64'(0));
    endtask

    initial begin
        int rq, dc, wb, exp_dc, exp_rq;
        logic [2:0]  f3;
        logic [31:0] a, d;
        bit          st_pushed;

        rst = 1'b1; load = 1'b0; store = 1'b0; funct3 = '0; addr = '0; store_data = '0;
        idle(3);
        rst = 1'b0;
        check_reset_vals("rst");
        @(posedge clk); #1;

        // LW, zero-wait: request in cycle 1, completion in cycle 2
        do_load(3'b010, 32'h100, 32'hDEAD_BEEF, 0, rq, dc);
        check("lw_req_cyc", 64'(rq), 64'(1));
        check("lw_dm_cyc", 64'(dc), 64'(2));
        check("lw_dm_pulse", 64'(dm_valid), 64'(0));

        do_load(3'b000, 32'h103, 32'h80FF_0000, 0, rq, dc);
        do_load(3'b100, 32'h103, 32'h80FF_0000, 0, rq, dc);
        do_load(3'b101, 32'h102, 32'h80FF_0000, 2, rq, dc);
        check("lhu_dm_cyc", 64'(dc), 64'(4));

        // store drains before a load issued in the very next cycle
        wb = wr_acks;
        do_store(3'b001, 32'h202, 32'h0000_1234, 1'b1);
        do_load(3'b010, 32'h200, 32'hCAFE_F00D, 0, rq, dc);
        check("shlw_wr_first", 64'(dm_wr_acks - wb), 64'(1));
        check("shlw_dm_late", 64'(dc > 2), 64'(1));

        // three stores against a stalled memory: third one is dropped
        hold_ack = 1'b1;
        do_store(3'b010, 32'h300, 32'h1111_1111, 1'b1);
        do_store(3'b010, 32'h304, 32'h2222_2222, 1'b1);
        @(negedge clk);
        check("sb_full_2", 64'(sb_full), 64'(1));
        @(posedge clk); #1;
        do_store(3'b010, 32'h308, 32'h3333_3333, 1'b0);
        @(negedge clk);
        check("sb_ovf_set", 64'(sb_overflow), 64'(1));
        check("st_hold_bus", 64'({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr}),
              64'({2'b11, 32'h300}));
        @(posedge clk); #1;
        cur_wait = 1;
        hold_ack = 1'b0;
        for (int k = 0; k < 40 && (exp_wr_q.size() != 0 || mem_bus.mem_req); k++) idle(1);
        idle(2);
        check("drain_done", 64'(exp_wr_q.size()), 64'(0));
        @(negedge clk);
        check("sb_full_clr", 64'(sb_full), 64'(0));
        check("sb_ovf_sticky", 64'(sb_overflow), 64'(1));
        @(posedge clk); #1;

        // illegal store: fault pulse next cycle, nothing written
        do_store(3'b001, 32'h301, 32'hABCD, 1'b0);
        @(negedge clk);
        check("st_fault_pulse", 64'(access_fault), 64'(1));
        @(negedge clk);
        check("st_fault_clear", 64'(access_fault), 64'(0));
        @(posedge clk); #1;
        do_store(3'b100, 32'h310, 32'h55, 1'b0);
        idle(2);

        // illegal loads complete without a memory access
        do_load(3'b010, 32'h101, 32'h1234_5678, 0, rq, dc);
        check("lw_mis_noreq", 64'(rq), 64'(-1));
        check("lw_mis_dm_cyc", 64'(dc), 64'(1));
        do_load(3'b011, 32'h104, 32'h1234_5678, 0, rq, dc);
        check("f3_rsv_noreq", 64'(rq), 64'(-1));

        // randomized mix of stores and loads
        for (int i = 0; i < 24; i++) begin
            st_pushed = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                f3 = 3'($urandom_range(0, 7));
                a  = 32'h1000 + $urandom_range(0, 63);
                if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
                st_pushed = st_legal(f3, a);
                do_store(f3, a, $urandom, st_pushed);
            end
            f3 = 3'($urandom_range(0, 7));
            a  = 32'h2000 + $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            d  = $urandom;
            wb = $urandom_range(0, 2);
            do_load(f3, a, d, wb, rq, dc);
            if (!st_pushed) begin
                exp_dc = ld_legal(f3, a) ? 2 + wb : 1;
                exp_rq = ld_legal(f3, a) ? 1 : -1;
                check("rnd_dm_cyc", 64'(dc), 64'(exp_dc));
                check("rnd_req_cyc", 64'(rq), 64'(exp_rq));
            end
        end
        cur_wait = 0;

        // reset while a load waits for its ack; the late ack must be ignored
        hold_ack = 1'b1;
        load = 1'b1; funct3 = 3'b010; addr = 32'h400;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_req", 64'(mem_bus.mem_req), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1; load = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; man_en = 1'b1; man_ack = 1'b1; hold_ack = 1'b0;
        check_reset_vals("rst_mid");
        @(posedge clk); #1;
        man_ack = 1'b0;
        check_reset_vals("rst_late");
        @(posedge clk); #1;
        man_en = 1'b0;
        idle(3);

        // normal operation resumes after the mid-transaction reset
        do_store(3'b000, 32'h501, 32'h0000_00A5, 1'b1);
        do_load(3'b000, 32'h501, 32'h0000_A500, 1, rq, dc);
        idle(4);

        check("exp_q_empty", 64'(exp_q.size()), 64'(0));
        check("wr_q_empty", 64'(exp_wr_q.size()), 64'(0));
        check("rd_q_empty", 64'(exp_rd_q.size()), 64'(0));
        check("store_faults", 64'(store_faults), 64'(exp_store_faults));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
